// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle, MSB first.
// Handles signed (truncate toward zero) and unsigned operands; divide-by-zero gives all-ones / dividend.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] part_q, part_d;  // partial remainder
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] step_part;
  logic [WIDTH-1:0] step_dvd;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    shifted   = {part_q, dvd_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvs_q};
    ge        = (shifted >= {1'b0, dvs_q});
    step_part = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_dvd  = {dvd_q[WIDTH-2:0], ge};
    // Magnitude of the most negative value wraps to itself, which yields the overflow result naturally.
    mag_a     = (is_signed && a[WIDTH-1]) ? ('0 - a) : a;
    mag_b     = (is_signed && b[WIDTH-1]) ? ('0 - b) : b;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    part_d  = part_q;
    dvs_d   = dvs_q;
    araw_d  = araw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH);
          dvd_d   = mag_a;
          dvs_d   = mag_b;
          part_d  = '0;
          araw_d  = a;
          qneg_d  = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d  = is_signed & a[WIDTH-1];
          dz_d    = (b == '0);
        end
      end
      CALC: begin
        part_d = step_part;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          if (dz_q) begin
            quo_d = '1;
            rem_d = araw_q;
          end else begin
            quo_d = qneg_q ? ('0 - step_dvd) : step_dvd;
            rem_d = rneg_q ? ('0 - step_part) : step_part;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything except reset; results stay at their previous values.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      quo_d   = quo_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      part_q  <= '0;
      dvs_q   <= '0;
      araw_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      part_q  <= part_d;
      dvs_q   <= dvs_d;
      araw_q  <= araw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quo       = quo_q;
  assign rem       = rem_q;
  assign dbg_state = state_q;

endmodule
